apb_h264_ctrl_regs: RTL and testbench



---
 rtl/apb_h264_ctrl_regs.sv | 162 ++++++++++++++++
 tb/tb_apb_h264_ctrl_regs.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_h264_ctrl_regs.sv
// APB3 control/status register bank for the H.264 encoder (FIC3 slave slot 1).
// Fixed one-wait-state access; sticky maskable frame-done interrupt and frame counter.
module apb_h264_ctrl_regs #(
    parameter int unsigned ADDR_LSB_W   = 8,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter logic [5:0]  QP_DEFAULT   = 6'd28,
    parameter logic [15:0] HRES_DEFAULT = 16'd1920,
    parameter logic [15:0] VRES_DEFAULT = 16'd1080
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDRS,
    input  logic        PSELS1,
    input  logic        PENABLES,
    input  logic        PWRITES,
    input  logic [31:0] PWDATAS,
    output logic [31:0] PRDATAS1,
    output logic        PREADYS1,
    output logic        PSLVERRS1,
    input  logic        frame_done_i,
    input  logic        enc_busy_i,
    output logic        enc_en_o,
    output logic        soft_rst_o,
    output logic [5:0]  qp_o,
    output logic [15:0] hres_o,
    output logic [15:0] vres_o,
    output logic        irq_o
);

    typedef enum logic {
        IDLE,
        DONE
    } state_t;

    state_t                state;
    logic                  wr_q;
    logic                  err_q;
    logic [2:0]            sel_q;
    logic [31:0]           wdata_q;
    logic [1:0]            irq_status;
    logic [1:0]            irq_en;
    logic [31:0]           frame_cnt;

    logic [ADDR_LSB_W-3:0] idx;
    logic [2:0]            reg_sel;
    logic                  mapped;
    logic                  acc_err;
    logic [31:0]           rd_mux;
    logic                  commit;
    logic                  wr_ctrl, wr_qp, wr_res, wr_irq_st, wr_irq_en, wr_fcnt;
    logic [1:0]            irq_clr;
    logic [1:0]            irq_set;
    logic                  unused_addr_bits;

    assign idx              = PADDRS[ADDR_LSB_W-1:2];
    assign reg_sel          = idx[2:0];
    assign mapped           = ((idx >> 3) == '0);
    assign unused_addr_bits = ^{PADDRS[31:ADDR_LSB_W], PADDRS[1:0]};

    always_comb begin
        acc_err = !mapped;
        if (PWRITES && (reg_sel == 3'd3 || reg_sel == 3'd7))
            acc_err = 1'b1;
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            3'd0: rd_mux = {31'd0, enc_en_o};
            3'd1: rd_mux = {26'd0, qp_o};
            3'd2: rd_mux = {vres_o, hres_o};
            3'd3: rd_mux = {31'd0, enc_busy_i};
            3'd4: rd_mux = {30'd0, irq_status};
            3'd5: rd_mux = {30'd0, irq_en};
            3'd6: rd_mux = frame_cnt;
            3'd7: rd_mux = VERSION;
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        commit    = (state == DONE) && wr_q && !err_q;
        wr_ctrl   = commit && (sel_q == 3'd0);
        wr_qp     = commit && (sel_q == 3'd1);
        wr_res    = commit && (sel_q == 3'd2);
        wr_irq_st = commit && (sel_q == 3'd4);
        wr_irq_en = commit && (sel_q == 3'd5);
        wr_fcnt   = commit && (sel_q == 3'd6);
        irq_clr   = wr_irq_st ? wdata_q[1:0] : 2'b00;
        irq_set   = {frame_done_i & irq_status[0], frame_done_i};
    end

    // The first ACCESS cycle (IDLE with PSEL&PENABLE) is the wait state: decode is
    // registered at its end so PREADY rises on the 2nd cycle, and DONE commits the write.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= IDLE;
            PRDATAS1   <= '0;
            PREADYS1   <= 1'b0;
            PSLVERRS1  <= 1'b0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            sel_q      <= '0;
            wdata_q    <= '0;
            enc_en_o   <= 1'b0;
            soft_rst_o <= 1'b0;
            qp_o       <= QP_DEFAULT;
            hres_o     <= HRES_DEFAULT;
            vres_o     <= VRES_DEFAULT;
            irq_status <= '0;
            irq_en     <= '0;
            frame_cnt  <= '0;
            irq_o      <= 1'b0;
        end else begin
            soft_rst_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (PSELS1 && PENABLES) begin
                        state     <= DONE;
                        PREADYS1  <= 1'b1;
                        PSLVERRS1 <= acc_err;
                        PRDATAS1  <= (PWRITES || acc_err) ? '0 : rd_mux;
                        wr_q      <= PWRITES;
                        err_q     <= acc_err;
                        sel_q     <= reg_sel;
                        wdata_q   <= PWDATAS;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    PREADYS1  <= 1'b0;
                    PSLVERRS1 <= 1'b0;
                    PRDATAS1  <= '0;
                end
                default: state <= IDLE;
            endcase

            if (wr_ctrl) begin
                enc_en_o   <= wdata_q[1] ? 1'b0 : wdata_q[0];
                soft_rst_o <= wdata_q[1];
            end
            if (wr_qp)
                qp_o <= (wdata_q > 32'd51) ? 6'd51 : wdata_q[5:0];
            if (wr_res) begin
                hres_o <= wdata_q[15:0];
                vres_o <= wdata_q[31:16];
            end
            if (wr_irq_en)
                irq_en <= wdata_q[1:0];

            irq_status <= (irq_status & ~irq_clr) | irq_set;

            if (wr_fcnt)
                frame_cnt <= frame_done_i ? 32'd1 : 32'd0;
            else if (frame_done_i)
                frame_cnt <= frame_cnt + 32'd1;

            irq_o <= |(irq_status & irq_en);
        end
    end

endmodule

// File: tb/tb_apb_h264_ctrl_regs.sv
// Directed self-checking bench for apb_h264_ctrl_regs.
module tb_apb_h264_ctrl_regs;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [31:0] PADDRS = '0;
    logic        PSELS1 = 1'b0;
    logic        PENABLES = 1'b0;
    logic        PWRITES = 1'b0;
    logic [31:0] PWDATAS = '0;
    logic [31:0] PRDATAS1;
    logic        PREADYS1;
    logic        PSLVERRS1;
    logic        frame_done_i = 1'b0;
    logic        enc_busy_i = 1'b0;
    logic        enc_en_o;
    logic        soft_rst_o;
    logic [5:0]  qp_o;
    logic [15:0] hres_o;
    logic [15:0] vres_o;
    logic        irq_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;
    logic        er;
    logic [5:0]  qp_at_done;

    apb_h264_ctrl_regs #(
        .ADDR_LSB_W  (8),
        .VERSION     (32'h0001_0000),
        .QP_DEFAULT  (6'd28),
        .HRES_DEFAULT(16'd1920),
        .VRES_DEFAULT(16'd1080)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .PADDRS      (PADDRS),
        .PSELS1      (PSELS1),
        .PENABLES    (PENABLES),
        .PWRITES     (PWRITES),
        .PWDATAS     (PWDATAS),
        .PRDATAS1    (PRDATAS1),
        .PREADYS1    (PREADYS1),
        .PSLVERRS1   (PSLVERRS1),
        .frame_done_i(frame_done_i),
        .enc_busy_i  (enc_busy_i),
        .enc_en_o    (enc_en_o),
        .soft_rst_o  (soft_rst_o),
        .qp_o        (qp_o),
        .hres_o      (hres_o),
        .vres_o      (vres_o),
        .irq_o       (irq_o)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Full APB transfer; optional frame_done_i pulse aligned with the completing cycle.
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic pulse, output logic [31:0] rdata, output logic err);
        @(posedge PCLK); #1;
        PSELS1 = 1'b1; PENABLES = 1'b0; PWRITES = wr; PADDRS = addr; PWDATAS = wdata;
        @(posedge PCLK); #1;
        PENABLES = 1'b1;
        @(negedge PCLK);
        check("pready_wait", {31'd0, PREADYS1}, 32'd0);
        check("prdata_wait", PRDATAS1, 32'd0);
        @(posedge PCLK); #1;
        if (pulse) frame_done_i = 1'b1;
        @(negedge PCLK);
        check("pready_done", {31'd0, PREADYS1}, 32'd1);
        rdata      = PRDATAS1;
        err        = PSLVERRS1;
        qp_at_done = qp_o;
        @(posedge PCLK); #1;
        PSELS1 = 1'b0; PENABLES = 1'b0; frame_done_i = 1'b0;
        @(negedge PCLK);
        check("pready_after", {31'd0, PREADYS1}, 32'd0);
        check("pslverr_after", {31'd0, PSLVERRS1}, 32'd0);
    endtask

    task automatic pulse_frame();
        @(posedge PCLK); #1;
        frame_done_i = 1'b1;
        @(posedge PCLK); #1;
        frame_done_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        check("rst_pready", {31'd0, PREADYS1}, 32'd0);
        check("rst_prdata", PRDATAS1, 32'd0);
        check("rst_pslverr", {31'd0, PSLVERRS1}, 32'd0);
        check("rst_enc_en", {31'd0, enc_en_o}, 32'd0);
        check("rst_soft_rst", {31'd0, soft_rst_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_qp", {26'd0, qp_o}, 32'd28);
        check("rst_hres", {16'd0, hres_o}, 32'd1920);
        check("rst_vres", {16'd0, vres_o}, 32'd1080);

        apb(1'b0, 32'h04, '0, 1'b0, rd, er);
        check("rd_qp", rd, 32'd28);
        check("rd_qp_err", {31'd0, er}, 32'd0);
        apb(1'b0, 32'h08, '0, 1'b0, rd, er);
        check("rd_res", rd, 32'h0438_0780);
        apb(1'b0, 32'h1C, '0, 1'b0, rd, er);
        check("rd_version", rd, 32'h0001_0000);
        check("rd_version_err", {31'd0, er}, 32'd0);

        apb(1'b1, 32'h04, 32'd60, 1'b0, rd, er);
        check("qp60_at_done", {26'd0, qp_at_done}, 32'd28);
        check("qp60_after", {26'd0, qp_o}, 32'd51);
        apb(1'b0, 32'h04, '0, 1'b0, rd, er);
        check("rd_qp_sat", rd, 32'd51);
        apb(1'b1, 32'h04, 32'd30, 1'b0, rd, er);
        check("qp30_at_done", {26'd0, qp_at_done}, 32'd51);
        check("qp30_after", {26'd0, qp_o}, 32'd30);
        apb(1'b0, 32'h04, '0, 1'b0, rd, er);
        check("rd_qp30", rd, 32'd30);

        enc_busy_i = 1'b1;
        apb(1'b1, 32'h0C, 32'hFFFF_FFFF, 1'b0, rd, er);
        check("wr_status_err", {31'd0, er}, 32'd1);
        check("wr_status_data", rd, 32'd0);
        apb(1'b1, 32'h40, 32'h1234_5678, 1'b0, rd, er);
        check("wr_unmapped_err", {31'd0, er}, 32'd1);
        apb(1'b0, 32'h40, '0, 1'b0, rd, er);
        check("rd_unmapped_err", {31'd0, er}, 32'd1);
        check("rd_unmapped_data", rd, 32'd0);
        apb(1'b0, 32'h0C, '0, 1'b0, rd, er);
        check("rd_status_busy", rd, 32'd1);
        check("rd_status_err", {31'd0, er}, 32'd0);
        enc_busy_i = 1'b0;
        apb(1'b0, 32'h0C, '0, 1'b0, rd, er);
        check("rd_status_idle", rd, 32'd0);
        check("qp_kept", {26'd0, qp_o}, 32'd30);

        apb(1'b1, 32'h14, 32'h1, 1'b0, rd, er);
        pulse_frame();
        pulse_frame();
        apb(1'b0, 32'h10, '0, 1'b0, rd, er);
        check("irq_status_ovf", rd, 32'h3);
        apb(1'b0, 32'h18, '0, 1'b0, rd, er);
        check("frame_cnt_2", rd, 32'd2);
        check("irq_set", {31'd0, irq_o}, 32'd1);

        apb(1'b1, 32'h10, 32'h1, 1'b1, rd, er);
        apb(1'b0, 32'h10, '0, 1'b0, rd, er);
        check("w1c_vs_set", rd, 32'h3);
        apb(1'b0, 32'h18, '0, 1'b0, rd, er);
        check("frame_cnt_3", rd, 32'd3);
        apb(1'b1, 32'h18, 32'h0, 1'b1, rd, er);
        apb(1'b0, 32'h18, '0, 1'b0, rd, er);
        check("cnt_clr_vs_pulse", rd, 32'd1);

        apb(1'b1, 32'h10, 32'h3, 1'b0, rd, er);
        check("irq_lag", {31'd0, irq_o}, 32'd1);
        @(negedge PCLK);
        check("irq_cleared", {31'd0, irq_o}, 32'd0);
        apb(1'b0, 32'h10, '0, 1'b0, rd, er);
        check("irq_status_clr", rd, 32'd0);

        apb(1'b1, 32'h00, 32'h1, 1'b0, rd, er);
        check("enc_en_set", {31'd0, enc_en_o}, 32'd1);
        check("soft_rst_idle", {31'd0, soft_rst_o}, 32'd0);
        apb(1'b1, 32'h00, 32'h3, 1'b0, rd, er);
        check("soft_rst_pulse", {31'd0, soft_rst_o}, 32'd1);
        check("enc_en_cleared", {31'd0, enc_en_o}, 32'd0);
        @(negedge PCLK);
        check("soft_rst_end", {31'd0, soft_rst_o}, 32'd0);
        apb(1'b0, 32'h00, '0, 1'b0, rd, er);
        check("rd_ctrl", rd, 32'd0);

        @(negedge PCLK);
        force dut.frame_cnt = 32'hFFFF_FFFF;
        @(negedge PCLK);
        release dut.frame_cnt;
        apb(1'b0, 32'h18, '0, 1'b0, rd, er);
        check("frame_cnt_max", rd, 32'hFFFF_FFFF);
        pulse_frame();
        apb(1'b0, 32'h18, '0, 1'b0, rd, er);
        check("frame_cnt_wrap", rd, 32'd0);

        @(posedge PCLK); #1;
        PSELS1 = 1'b1; PENABLES = 1'b0; PWRITES = 1'b1; PADDRS = 32'h08; PWDATAS = 32'h0010_0020;
        @(posedge PCLK); #1;
        PENABLES = 1'b1; PRESET = 1'b1;
        @(negedge PCLK);
        check("rst_mid_pready", {31'd0, PREADYS1}, 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSELS1 = 1'b0; PENABLES = 1'b0;
        @(negedge PCLK);
        check("rst_mid_pready2", {31'd0, PREADYS1}, 32'd0);
        @(negedge PCLK);
        check("rst_mid_hres", {16'd0, hres_o}, 32'd1920);
        check("rst_mid_vres", {16'd0, vres_o}, 32'd1080);
        apb(1'b0, 32'h08, '0, 1'b0, rd, er);
        check("rst_mid_rd_res", rd, 32'h0438_0780);
        check("rst_mid_rd_err", {31'd0, er}, 32'd0);
        apb(1'b0, 32'h04, '0, 1'b0, rd, er);
        check("rst_mid_rd_qp", rd, 32'd28);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
